// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed BCD to 7-segment scan driver with double-buffered display value.
// Define BCD7SEG_DP_EN to add the per-digit decimal point (dp_in/dp).
module bcd_7seg_scan_driver #(
    parameter int unsigned NUM_DIGITS      = 4,
    parameter int unsigned REFRESH_DIV     = 1000,
    parameter bit          SEG_ACTIVE_HIGH = 1'b1,
    parameter bit          DIG_ACTIVE_HIGH = 1'b1,
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
    input  logic                    blank_lz,
`ifdef BCD7SEG_DP_EN
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    dp,
`endif
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        dig_idx,
    output logic                    frame_done,
    output logic                    upd_ack,
    output logic                    bcd_err
);

    localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [6:0] SEG_OFF = {7{~SEG_ACTIVE_HIGH}};
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{~DIG_ACTIVE_HIGH}};

    logic [PRE_W-1:0]                pre_cnt;
    logic [NUM_DIGITS-1:0][3:0]      disp;
    logic [NUM_DIGITS-1:0][3:0]      pend;
    logic                            pend_vld;
`ifdef BCD7SEG_DP_EN
    logic [NUM_DIGITS-1:0]           disp_dp;
    logic [NUM_DIGITS-1:0]           pend_dp;
`endif

    logic                  pre_tc;
    logic                  last_dig;
    logic                  wrap;
    logic                  bcd_bad;
    logic                  blank;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1111110;
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b1011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1111011;
            default: decode = 7'b0000000;
        endcase
    endfunction

    assign pre_tc   = (pre_cnt == PRE_W'(REFRESH_DIV - 1));
    assign last_dig = (dig_idx == IDX_W'(NUM_DIGITS - 1));
    assign wrap     = pre_tc && last_dig;

    always_comb begin
        bcd_bad = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bcd_bad = 1'b1;
            end
        end
    end

    // upper_zero[i]: displayed digits i..N-1 are all zero
    always_comb begin
        upper_zero = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            upper_zero[i] = ((disp >> (4 * i)) == '0);
        end
    end

    always_comb begin
        blank    = blank_lz && (dig_idx != '0) && upper_zero[dig_idx];
        seg_next = (blank ? 7'b0000000 : decode(disp[dig_idx])) ^ SEG_OFF;
        an_next  = (NUM_DIGITS'(1) << dig_idx) ^ AN_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt    <= '0;
            dig_idx    <= '0;
            disp       <= '0;
            pend       <= '0;
            pend_vld   <= 1'b0;
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
            upd_ack    <= 1'b0;
            bcd_err    <= 1'b0;
`ifdef BCD7SEG_DP_EN
            disp_dp    <= '0;
            pend_dp    <= '0;
            dp         <= 1'b0;
`endif
        end else begin
            frame_done <= wrap;
            upd_ack    <= 1'b0;

            if (pre_tc) begin
                pre_cnt <= '0;
                dig_idx <= last_dig ? '0 : dig_idx + IDX_W'(1);
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end

            if (load) begin
                bcd_err <= bcd_bad;
            end

            // A load on the wrap cycle bypasses the pending buffer
            if (wrap) begin
                if (load) begin
                    disp     <= bcd_in;
                    pend_vld <= 1'b0;
                    upd_ack  <= 1'b1;
`ifdef BCD7SEG_DP_EN
                    disp_dp  <= dp_in;
`endif
                end else if (pend_vld) begin
                    disp     <= pend;
                    pend_vld <= 1'b0;
                    upd_ack  <= 1'b1;
`ifdef BCD7SEG_DP_EN
                    disp_dp  <= pend_dp;
`endif
                end
            end else if (load) begin
                pend     <= bcd_in;
                pend_vld <= 1'b1;
`ifdef BCD7SEG_DP_EN
                pend_dp  <= dp_in;
`endif
            end

            seg <= seg_next;
            an  <= an_next;
`ifdef BCD7SEG_DP_EN
            dp  <= disp_dp[dig_idx] ^ ~SEG_ACTIVE_HIGH;
`endif
        end
    end

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Scoreboard bench for bcd_7seg_scan_driver: a time-based reference model queues the
// expected outputs for each clock edge and a monitor compares them.
module tb_bcd_7seg_scan_driver;

    localparam int N = 4;
    localparam int R = 4;
    localparam int FRAME = N * R;
    localparam bit SEG_AH = 1'b1;
    localparam bit DIG_AH = 1'b1;

    logic          clk;
    logic          rst;
    logic [15:0]   bcd_in;
    logic          load;
    logic          blank_lz;
    logic [6:0]    seg;
    logic [3:0]    an;
    logic [1:0]    dig_idx;
    logic          frame_done;
    logic          upd_ack;
    logic          bcd_err;
`ifdef BCD7SEG_DP_EN
    logic [3:0]    dp_in;
    logic          dp;
    assign dp_in = '0;
`endif

    bcd_7seg_scan_driver #(
        .NUM_DIGITS      (N),
        .REFRESH_DIV     (R),
        .SEG_ACTIVE_HIGH (SEG_AH),
        .DIG_ACTIVE_HIGH (DIG_AH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .load       (load),
        .blank_lz   (blank_lz),
`ifdef BCD7SEG_DP_EN
        .dp_in      (dp_in),
        .dp         (dp),
`endif
        .seg        (seg),
        .an         (an),
        .dig_idx    (dig_idx),
        .frame_done (frame_done),
        .upd_ack    (upd_ack),
        .bcd_err    (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] an;
        logic [1:0] idx;
        logic       fd;
        logic       ack;
        logic       err;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // Reference model state: edges since reset release and the value seen by the viewer
    int          k;
    logic [15:0] shown;
    logic [15:0] pend;
    bit          pv;
    bit          err;
    bit          cur_blz;
    logic [6:0]  tbl[16];

    initial begin
        tbl[0] = 7'b1111110; tbl[1] = 7'b0110000; tbl[2] = 7'b1101101; tbl[3] = 7'b1111001;
        tbl[4] = 7'b0110011; tbl[5] = 7'b1011011; tbl[6] = 7'b1011111; tbl[7] = 7'b1110000;
        tbl[8] = 7'b1111111; tbl[9] = 7'b1111011;
        for (int i = 10; i < 16; i++) tbl[i] = 7'b0000000;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    function automatic bit has_bad(input logic [15:0] v);
        for (int i = 0; i < N; i++) begin
            if (((v >> (4 * i)) & 16'hF) > 16'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Called at a falling edge: drive inputs, queue what the next rising edge must produce
    task automatic cycle(input bit ld, input logic [15:0] val, input bit blz);
        exp_t        e;
        int          dig;
        logic [15:0] up;
        bit          boundary;
        load     = ld;
        bcd_in   = val;
        blank_lz = blz;
        dig      = (k / R) % N;
        up       = shown >> (4 * dig);
        boundary = (k % FRAME) == FRAME - 1;
        e.seg    = (blz && dig > 0 && up == 16'd0) ? 7'b0000000 : tbl[up[3:0]];
        if (!SEG_AH) e.seg = ~e.seg;
        e.an     = 4'(1 << dig);
        if (!DIG_AH) e.an = ~e.an;
        e.idx    = 2'(((k + 1) / R) % N);
        e.fd     = boundary;
        e.ack    = boundary && (ld || pv);
        if (ld) err = has_bad(val);
        if (boundary) begin
            if (ld) shown = val;
            else if (pv) shown = pend;
            pv = 1'b0;
        end else if (ld) begin
            pend = val;
            pv   = 1'b1;
        end
        e.err = err;
        q.push_back(e);
        k++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom), cur_blz);
    endtask

    task automatic idle_until(input int phase);
        while ((k % FRAME) != phase) cycle(1'b0, 16'($urandom), cur_blz);
    endtask

    task automatic check_reset_state();
        chk("rst_seg", 32'(seg), SEG_AH ? 32'h00 : 32'h7F);
        chk("rst_an", 32'(an), DIG_AH ? 32'h0 : 32'hF);
        chk("rst_idx", 32'(dig_idx), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        chk("rst_ack", 32'(upd_ack), 32'd0);
        chk("rst_err", 32'(bcd_err), 32'd0);
    endtask

    task automatic release_reset();
        rst   = 1'b0;
        k     = 0;
        shown = '0;
        pend  = '0;
        pv    = 1'b0;
        err   = 1'b0;
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        if ($urandom_range(0, 3) == 0) return 16'($urandom);
        v = '0;
        for (int i = 0; i < N; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 2) == 0) v[15:8] = 8'h00;
        return v;
    endfunction

    // Monitor: one comparison set per rising edge outside reset
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && q.size() > 0) begin
                e = q.pop_front();
                chk("seg", 32'(seg), 32'(e.seg));
                chk("an", 32'(an), 32'(e.an));
                chk("dig_idx", 32'(dig_idx), 32'(e.idx));
                chk("frame_done", 32'(frame_done), 32'(e.fd));
                chk("upd_ack", 32'(upd_ack), 32'(e.ack));
                chk("bcd_err", 32'(bcd_err), 32'(e.err));
            end
        end
    end

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        bcd_in   = '0;
        blank_lz = 1'b0;
        cur_blz  = 1'b0;
        k        = 0;
        @(negedge clk);
        check_reset_state();
        @(negedge clk);
        release_reset();

        // Idle scan of value 0
        idle(2 * FRAME);

        // Mid-frame load shows only after the wrap
        idle_until(5);
        cycle(1'b1, 16'h1234, cur_blz);
        idle(2 * FRAME);

        // Second load in the same frame overwrites the first
        idle_until(2);
        cycle(1'b1, 16'h0005, cur_blz);
        idle(3);
        cycle(1'b1, 16'h0042, cur_blz);
        idle(2 * FRAME);

        // Leading-zero blanking
        cur_blz = 1'b1;
        idle(FRAME);
        idle_until(3);
        cycle(1'b1, 16'h0000, cur_blz);
        idle(2 * FRAME);

        // Out-of-range digit sets bcd_err, a clean load clears it
        idle_until(4);
        cycle(1'b1, 16'h00A9, cur_blz);
        idle(2 * FRAME);
        cycle(1'b1, 16'h0009, cur_blz);
        idle(2 * FRAME);

        // Load exactly on the wrap cycle, with and without a pending value
        cur_blz = 1'b0;
        idle_until(FRAME - 1);
        cycle(1'b1, 16'h5678, cur_blz);
        idle(FRAME);
        idle_until(8);
        cycle(1'b1, 16'h1111, cur_blz);
        idle_until(FRAME - 1);
        cycle(1'b1, 16'h2222, cur_blz);
        idle(2 * FRAME);

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 15) == 0) cur_blz = ~cur_blz;
            cycle($urandom_range(0, 7) == 0, rand_val(), cur_blz);
        end

        // Reset mid-frame with a pending load
        idle_until(6);
        cycle(1'b1, 16'h9999, cur_blz);
        idle(2);
        rst = 1'b1;
        #1;
        check_reset_state();
        @(negedge clk);
        release_reset();
        cur_blz = 1'b0;
        idle(3 * FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
